// File: rtl/unisys_pkg.sv
// +----------------------------------------------------------------------------+
// | unisys_pkg: shared register offsets, status bit indices and bus mode enum  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package unisys_pkg;

    localparam logic [7:0] c_ofs_kbd_data  = 8'h00;
    localparam logic [7:0] c_ofs_kbd_stat  = 8'h04;
    localparam logic [7:0] c_ofs_uart_data = 8'h08;
    localparam logic [7:0] c_ofs_uart_stat = 8'h0C;

    localparam int c_kbd_empty_bit = 8;
    localparam int c_kbd_full_bit  = 9;
    localparam int c_kbd_ovf_bit   = 10;
    localparam int c_kbd_perr_bit  = 11;

    localparam int c_uart_valid_bit = 0;
    localparam int c_uart_ovr_bit   = 1;
    localparam int c_uart_ferr_bit  = 2;

    typedef enum logic [2:0] {
        MODE_BYTE = 3'd0,
        MODE_HALF = 3'd1,
        MODE_WORD = 3'd2
    } bus_mode_t;

endpackage

`default_nettype wire

// File: rtl/unisys_soc_ps2_rx.sv
// +----------------------------------------------------------------------------+
// | unisys_soc_ps2_rx: PS/2 frame decoder, emits a byte with valid/err pulses  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module unisys_soc_ps2_rx #(
    parameter int PS2_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_s,
    input  logic       ps2_data_s,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);
    localparam int TW = $clog2(PS2_TIMEOUT + 1);

    logic          r_clk_d;
    logic [3:0]    r_bitcnt;
    logic [10:0]   r_shift;
    logic [TW-1:0] r_tmo;

    logic        w_fall;
    logic [10:0] w_frame;
    logic        w_ok;

    assign w_fall  = r_clk_d & ~ps2_clk_s;
    assign w_frame = {ps2_data_s, r_shift[10:1]};
    // start low, stop high, odd parity over data+parity
    assign w_ok    = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_d  <= 1'b1;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tmo    <= '0;
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_clk_d <= ps2_clk_s;
            valid   <= 1'b0;
            err     <= 1'b0;
            if (w_fall) begin
                r_tmo   <= '0;
                r_shift <= w_frame;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    data     <= w_frame[8:1];
                    valid    <= w_ok;
                    err      <= ~w_ok;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_tmo == TW'(PS2_TIMEOUT - 1)) begin
                    r_bitcnt <= '0;
                    r_tmo    <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/unisys_soc_uart_rx.sv
// +----------------------------------------------------------------------------+
// | unisys_soc_uart_rx: 8N1 UART receiver with mid-bit sampling                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module unisys_soc_uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_s,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);
    localparam int BIT  = CLK_HZ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            data    <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            valid <= 1'b0;
            ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CW'(BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CW'(BIT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (rx_s) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/unisys_soc.sv
// +----------------------------------------------------------------------------+
// | unisys_soc: PS/2 + UART receive front end behind a memory-mapped slave     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module unisys_soc #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int KBD_DEPTH   = 8,
    parameter int PS2_TIMEOUT = 2048
) (
    input  logic        ext_clock,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        bus_req,
    input  logic        bus_wen,
    input  logic [2:0]  bus_mode,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] bus_dat_o,
    output logic        bus_ready,
    output logic        irq
);
    import unisys_pkg::*;

    localparam int AW = $clog2(KBD_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0] r_ps2c_sync, r_ps2d_sync, r_rx_sync;

    logic [7:0]    r_mem [KBD_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_kbd_ovf, r_kbd_perr;
    logic [7:0]    r_uart_data;
    logic          r_uart_valid, r_uart_ovr, r_uart_ferr;

    logic [7:0]  w_ps2_data, w_uart_data;
    logic        w_ps2_valid, w_ps2_err, w_uart_valid, w_uart_ferr;
    logic        w_empty, w_full, w_access, w_rd, w_wr;
    logic        w_sel_kd, w_sel_ks, w_sel_ud, w_sel_us;
    logic        w_push, w_pop, w_uart_rd;
    logic [31:0] w_kbd_stat, w_rdata;

    always_ff @(posedge ext_clock or posedge rst) begin
        if (rst) begin
            r_ps2c_sync <= 2'b11;
            r_ps2d_sync <= 2'b11;
            r_rx_sync   <= 2'b11;
        end else begin
            r_ps2c_sync <= {r_ps2c_sync[0], ps2_clk};
            r_ps2d_sync <= {r_ps2d_sync[0], ps2_data};
            r_rx_sync   <= {r_rx_sync[0], uart_rx};
        end
    end

    unisys_soc_ps2_rx #(.PS2_TIMEOUT(PS2_TIMEOUT)) u_ps2_rx (
        .clk        (ext_clock),
        .rst        (rst),
        .ps2_clk_s  (r_ps2c_sync[1]),
        .ps2_data_s (r_ps2d_sync[1]),
        .data       (w_ps2_data),
        .valid      (w_ps2_valid),
        .err        (w_ps2_err)
    );

    unisys_soc_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart_rx (
        .clk   (ext_clock),
        .rst   (rst),
        .rx_s  (r_rx_sync[1]),
        .data  (w_uart_data),
        .valid (w_uart_valid),
        .ferr  (w_uart_ferr)
    );

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(KBD_DEPTH));
    // a held request is re-sampled only after the ready cycle
    assign w_access  = bus_req & ~bus_ready;
    assign w_rd      = w_access & ~bus_wen;
    assign w_wr      = w_access & bus_wen;
    assign w_sel_kd  = (bus_addr[7:2] == c_ofs_kbd_data[7:2]);
    assign w_sel_ks  = (bus_addr[7:2] == c_ofs_kbd_stat[7:2]);
    assign w_sel_ud  = (bus_addr[7:2] == c_ofs_uart_data[7:2]);
    assign w_sel_us  = (bus_addr[7:2] == c_ofs_uart_stat[7:2]);
    assign w_push    = w_ps2_valid & ~w_full;
    assign w_pop     = w_rd & w_sel_kd & ~w_empty;
    assign w_uart_rd = w_rd & w_sel_ud;

    always_comb begin
        w_kbd_stat                  = '0;
        w_kbd_stat[CW-1:0]          = r_count;
        w_kbd_stat[c_kbd_empty_bit] = w_empty;
        w_kbd_stat[c_kbd_full_bit]  = w_full;
        w_kbd_stat[c_kbd_ovf_bit]   = r_kbd_ovf;
        w_kbd_stat[c_kbd_perr_bit]  = r_kbd_perr;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_kd && !w_empty) w_rdata = {23'b0, 1'b1, r_mem[r_rptr]};
        else if (w_sel_ks)        w_rdata = w_kbd_stat;
        else if (w_sel_ud)        w_rdata = {23'b0, r_uart_valid, r_uart_data};
        else if (w_sel_us)        w_rdata = {29'b0, r_uart_ferr, r_uart_ovr, r_uart_valid};
    end

    always_ff @(posedge ext_clock) begin
        if (w_push) r_mem[r_wptr] <= w_ps2_data;
    end

    always_ff @(posedge ext_clock or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_kbd_ovf    <= 1'b0;
            r_kbd_perr   <= 1'b0;
            r_uart_data  <= '0;
            r_uart_valid <= 1'b0;
            r_uart_ovr   <= 1'b0;
            r_uart_ferr  <= 1'b0;
            bus_ready    <= 1'b0;
            bus_dat_o    <= '0;
            irq          <= 1'b0;
        end else begin
            bus_ready <= w_access;
            if (w_rd) bus_dat_o <= w_rdata;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (w_ps2_valid && w_full)                               r_kbd_ovf <= 1'b1;
            else if (w_wr && w_sel_ks && bus_dat_i[c_kbd_ovf_bit])   r_kbd_ovf <= 1'b0;
            if (w_ps2_err)                                           r_kbd_perr <= 1'b1;
            else if (w_wr && w_sel_ks && bus_dat_i[c_kbd_perr_bit])  r_kbd_perr <= 1'b0;

            // a byte arriving on the same edge as the read that frees the slot is kept
            if (w_uart_valid) begin
                if (r_uart_valid && !w_uart_rd) begin
                    r_uart_ovr <= 1'b1;
                end else begin
                    r_uart_data  <= w_uart_data;
                    r_uart_valid <= 1'b1;
                end
            end else if (w_uart_rd) begin
                r_uart_valid <= 1'b0;
            end
            if (w_wr && w_sel_us && bus_dat_i[c_uart_ovr_bit] && !(w_uart_valid && r_uart_valid))
                r_uart_ovr <= 1'b0;
            if (w_uart_ferr)                                         r_uart_ferr <= 1'b1;
            else if (w_wr && w_sel_us && bus_dat_i[c_uart_ferr_bit]) r_uart_ferr <= 1'b0;

            irq <= ~w_empty | r_uart_valid;
        end
    end

    bus_mode_t w_mode_unused;
    logic      w_unused;
    assign w_mode_unused = bus_mode_t'(bus_mode);
    assign w_unused = &{1'b0, w_mode_unused, bus_addr[1:0], bus_dat_i[31:12],
                        bus_dat_i[9:3], bus_dat_i[0]};

endmodule

`default_nettype wire

// File: tb/tb_unisys_soc.sv
// +----------------------------------------------------------------------------+
// | tb_unisys_soc: scoreboard bench for the unisys_soc PS/2 and UART front end |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_unisys_soc;
    localparam int BIT_NS = (100_000_000 / 115200) * 10;

    logic        ext_clock = 1'b0;
    logic        rst       = 1'b1;
    logic        uart_rx   = 1'b1;
    logic        ps2_clk   = 1'b1;
    logic        ps2_data  = 1'b1;
    logic        bus_req   = 1'b0;
    logic        bus_wen   = 1'b0;
    logic [2:0]  bus_mode  = 3'd2;
    logic [7:0]  bus_addr  = 8'h00;
    logic [31:0] bus_dat_i = 32'h0;
    logic [31:0] bus_dat_o;
    logic        bus_ready;
    logic        irq;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    unisys_soc dut (
        .ext_clock (ext_clock),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .bus_req   (bus_req),
        .bus_wen   (bus_wen),
        .bus_mode  (bus_mode),
        .bus_addr  (bus_addr),
        .bus_dat_i (bus_dat_i),
        .bus_dat_o (bus_dat_o),
        .bus_ready (bus_ready),
        .irq       (irq)
    );

    always #5 ext_clock = ~ext_clock;

    // monitor: every completed access pops one expectation
    always @(negedge ext_clock) begin
        if (!rst && bus_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: bus_dat_o=0x%0h with no access pending", bus_dat_o);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.chk) begin
                    n_chk++;
                    if (bus_dat_o !== mon_e.val) begin
                        n_fail++;
                        $display("FAIL %s: bus_dat_o=0x%0h expected 0x%0h", mon_e.nm, bus_dat_o, mon_e.val);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] v, input string nm);
        exp_t e;
        e.chk = 1'b1; e.val = v; e.nm = nm;
        @(negedge ext_clock);
        q.push_back(e);
        bus_addr = a; bus_wen = 1'b0; bus_req = 1'b1;
        @(negedge ext_clock);
        bus_req = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.chk = 1'b0; e.val = '0; e.nm = "write";
        @(negedge ext_clock);
        q.push_back(e);
        bus_addr = a; bus_wen = 1'b1; bus_dat_i = d; bus_req = 1'b1;
        @(negedge ext_clock);
        bus_req = 1'b0; bus_wen = 1'b0;
    endtask

    task automatic ps2_send(input logic [7:0] d, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        @(negedge ext_clock);
        #2;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            #15 ps2_clk = 1'b0;
            #30 ps2_clk = 1'b1;
            #15;
        end
        ps2_data = 1'b1;
        #10000;
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop);
        @(negedge ext_clock);
        #2;
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(BIT_NS);
        end
        // stop level held well past mid-bit, then line returns idle early
        uart_rx = stop;
        #(BIT_NS / 2 + 100);
        uart_rx = 1'b1;
        #(BIT_NS - BIT_NS / 2 - 100);
        #(BIT_NS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge ext_clock);
        check("reset_dat_o", bus_dat_o, 32'h0);
        check("reset_ready", {31'b0, bus_ready}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge ext_clock);

        bus_rd(8'h04, 32'h100, "reset_kbd_stat");
        bus_rd(8'h0C, 32'h0, "reset_uart_stat");
        bus_rd(8'h10, 32'h0, "unmapped_read");

        // req held high for four cycles completes twice
        begin
            exp_t e;
            e.chk = 1'b1; e.val = 32'h100; e.nm = "held_req";
            @(negedge ext_clock);
            q.push_back(e);
            q.push_back(e);
            bus_addr = 8'h04; bus_wen = 1'b0; bus_req = 1'b1;
            repeat (4) @(negedge ext_clock);
            bus_req = 1'b0;
        end

        // four scancodes
        ps2_send(8'hAA, 1'b0, 11);
        ps2_send(8'h52, 1'b0, 11);
        ps2_send(8'hF0, 1'b0, 11);
        ps2_send(8'h52, 1'b0, 11);
        check("irq_fifo", {31'b0, irq}, 32'h1);
        bus_rd(8'h04, 32'h004, "kbd_stat_4");
        bus_rd(8'h00, 32'h1AA, "kbd_data_aa");
        bus_rd(8'h00, 32'h152, "kbd_data_52a");
        bus_rd(8'h00, 32'h1F0, "kbd_data_f0");
        bus_rd(8'h00, 32'h152, "kbd_data_52b");
        bus_rd(8'h00, 32'h000, "kbd_data_empty");
        check("irq_after_pop", {31'b0, irq}, 32'h0);

        // parity error
        ps2_send(8'hAA, 1'b1, 11);
        bus_rd(8'h04, 32'h900, "kbd_stat_perr");
        bus_wr(8'h04, 32'h800);
        bus_rd(8'h04, 32'h100, "kbd_stat_perr_clr");

        // overflow
        for (int i = 1; i <= 9; i++) ps2_send(8'(i), 1'b0, 11);
        bus_rd(8'h04, 32'h608, "kbd_stat_full");
        for (int i = 1; i <= 8; i++) bus_rd(8'h00, 32'h100 | 32'(i), $sformatf("kbd_data_%0d", i));
        bus_rd(8'h04, 32'h500, "kbd_stat_ovf");
        bus_wr(8'h04, 32'h400);
        bus_rd(8'h04, 32'h100, "kbd_stat_ovf_clr");

        // partial frame discarded by timeout
        ps2_send(8'hFF, 1'b0, 5);
        #15000;
        ps2_send(8'h1C, 1'b0, 11);
        bus_rd(8'h00, 32'h11C, "kbd_data_1c");
        bus_rd(8'h00, 32'h000, "kbd_data_after_tmo");
        bus_rd(8'h04, 32'h100, "kbd_stat_after_tmo");

        // UART
        uart_send(8'h55, 1'b1);
        bus_rd(8'h0C, 32'h1, "uart_stat_valid");
        check("irq_uart", {31'b0, irq}, 32'h1);
        bus_rd(8'h08, 32'h155, "uart_data_55");
        bus_rd(8'h0C, 32'h0, "uart_stat_clr");
        uart_send(8'hA5, 1'b1);
        uart_send(8'h3C, 1'b1);
        bus_rd(8'h0C, 32'h3, "uart_stat_ovr");
        bus_rd(8'h08, 32'h1A5, "uart_data_a5");
        bus_wr(8'h0C, 32'h6);
        bus_rd(8'h0C, 32'h0, "uart_stat_ovr_clr");
        uart_send(8'h77, 1'b0);
        bus_rd(8'h0C, 32'h4, "uart_stat_ferr");
        check("irq_ferr_only", {31'b0, irq}, 32'h0);

        // reset mid-frame
        ps2_send(8'h33, 1'b0, 11);
        check("irq_before_rst", {31'b0, irq}, 32'h1);
        ps2_send(8'h52, 1'b0, 5);
        @(negedge ext_clock);
        #2 rst = 1'b1;
        #3;
        check("rst_dat_o", bus_dat_o, 32'h0);
        check("rst_ready", {31'b0, bus_ready}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        repeat (3) @(negedge ext_clock);
        rst = 1'b0;
        repeat (2) @(negedge ext_clock);
        bus_rd(8'h04, 32'h100, "rst_kbd_stat");
        bus_rd(8'h0C, 32'h0, "rst_uart_stat");
        ps2_send(8'h52, 1'b0, 11);
        bus_rd(8'h00, 32'h152, "post_rst_data");
        bus_rd(8'h04, 32'h100, "post_rst_stat");

        repeat (4) @(negedge ext_clock);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unisys_soc.md
# unisys_soc

I/O front end of the unisys SoC, the peripheral shell between the board pins and the system bus. It receives PS/2 keyboard scancodes into a FIFO and UART bytes into a holding register. Both are exposed to the CPU core through a memory-mapped bus slave port, and an interrupt is raised while data is pending. The CPU core and main memory are separate blocks on the same bus.

## Interface
Parameters:
- CLK_HZ, 100_000_000 — ext_clock frequency.
- BAUD, 115200 — UART bit rate. Bit period is CLK_HZ/BAUD cycles, truncated.
- KBD_DEPTH, 8 — scancode FIFO depth. Must be a power of two.
- PS2_TIMEOUT, 2048 — idle cycles after which a partial PS/2 frame is discarded.

Ports:
- ext_clock  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- uart_rx  in  1  UART serial input, idle high.
- ps2_clk  in  1  PS/2 clock from the keyboard, idle high.
- ps2_data  in  1  PS/2 data from the keyboard.
- bus_req  in  1  bus access request.
- bus_wen  in  1  1 = write, 0 = read.
- bus_mode  in  3  access size. Accepted but ignored; all accesses are full-word.
- bus_addr  in  8  byte offset. Bits [1:0] are ignored.
- bus_dat_i  in  32  write data.
- bus_dat_o  out  32  read data.
- bus_ready  out  1  access complete.
- irq  out  1  high while the FIFO is non-empty or UART data is valid.

## Operation
- ps2_clk, ps2_data, and uart_rx each pass through a 2-flop synchronizer.
- PS/2 receiver:
  - Samples data on each synchronized falling edge of ps2_clk and shifts an 11-bit frame LSB-first: start, 8 data bits, parity, stop.
  - Frame is valid when start=0, stop=1, and the 9 bits data+parity have odd parity.
  - Valid frame: data is pushed to the FIFO.
  - Invalid frame: dropped, and sticky kbd_perr is set.
  - PS2_TIMEOUT cycles with no falling edge mid-frame resets the bit counter.
- Scancode FIFO:
  - Push when full drops the new byte and sets sticky kbd_ovf. Existing contents are kept.
  - Count range is 0..KBD_DEPTH.
- UART receiver, 8N1:
  - A low level on uart_rx starts a frame. Start bit is re-checked at half a bit period; if high, the frame is aborted.
  - Data bits are sampled mid-bit, LSB first.
  - Stop bit = 0: byte discarded, sticky uart_ferr set.
  - Byte arriving while uart_valid=1: old byte kept, sticky uart_ovr set.
- Register map, byte offsets:
  - 0x00 KBD_DATA, read: {23'b0, valid, code}. Reading pops the FIFO. When empty, reads 0 and nothing is popped.
  - 0x04 KBD_STAT: [KBD_DEPTH width+1 : 0] count, [8] empty, [9] full, [10] kbd_ovf, [11] kbd_perr. Writing 1 to bit 10 or 11 clears that bit.
  - 0x08 UART_DATA, read: {23'b0, valid, byte}. Reading clears uart_valid.
  - 0x0C UART_STAT: [0] uart_valid, [1] uart_ovr, [2] uart_ferr. Writing 1 clears bits 1 and 2.
  - All other offsets read 0. Writes to them and to data registers are ignored.
- Same-cycle push and pop on the FIFO are both performed; count is unchanged.

## Timing
- Reset values:
  - bus_dat_o=0, bus_ready=0, irq=0.
  - FIFO empty, all sticky flags 0, uart_valid=0.
  - Both receivers idle.
- Reset mid-frame abandons the frame. No push occurs.
- Bus handshake:
  - Sampled on the cycle bus_req=1 and bus_ready=0.
  - One cycle later, bus_ready=1 for exactly one cycle, with bus_dat_o valid.
  - Pop or clear side effects happen on the sampling edge.
  - A req held high completes once per two cycles.
  - bus_dat_o holds its last value otherwise.
- PS/2 push: scancode is visible in KBD_STAT count at most 4 cycles after the 11th falling edge on the pin.
- UART: byte is visible at most 3 cycles after the mid-point of the stop bit.
- irq is registered and follows status with 1 cycle of latency.

## Structure
- Shared package unisys_pkg holds:
  - register offset constants;
  - status bit indices;
  - the bus mode enum.
- Natural sub-modules:
  - ps2_rx: frame decoder, outputs a byte plus a valid/error pulse.
  - uart_rx_8n1.
- The FIFO and register decode stay in the top.

## Test plan
- PS/2 frames 0xAA, 0x52, 0xF0, 0x52 at a 60 ns ps2_clk period, with 10 µs gaps. Expect KBD_STAT count=4. Four KBD_DATA reads return 0x1AA, 0x152, 0x1F0, 0x152, then 0x000. irq falls after the last pop.
- Frame 0xAA with the parity bit flipped. Expect count=0 and KBD_STAT[11]=1. Writing 0x800 to KBD_STAT clears the flag.
- Nine valid frames 0x01..0x09. Expect count=8, full=1, kbd_ovf=1. Reads return 0x101..0x108.
- Drop ps2_clk activity after 5 bits for more than PS2_TIMEOUT cycles, then send a full 0x1C frame. Only 0x11C is queued.
- UART 0x55 at 115200 baud. Expect UART_STAT=0x1 and UART_DATA=0x155, then UART_STAT=0. A second byte sent without reading sets uart_ovr. A stop bit of 0 sets uart_ferr.
- Assert rst mid-PS/2-frame. Expect all outputs 0 and the FIFO empty. The next complete frame is received correctly.
